wakeup_scoreboard: RTL
======================

# wakeup_scoreboard

Parametrised per-physical-register wakeup scoreboard for the out-of-order backend, and successor to the fixed two-wide scoreboard. It sits between rename/dispatch and the reservation stations. For every dispatched source tag it supplies the match bit, the countdown shift register and the latency delay vector the wakeup logic needs. It adds four things the previous block lacked:
- configurable dispatch and issue width;
- per-class latencies;
- same-cycle intra-group and broadcast forwarding;
- mask-based flush recovery.

## Interface
Parameters:
- PHY_REG_NUM, 64: number of physical registers.
- PHY_REG_SEL, 6: tag width, log2(PHY_REG_NUM).
- DISPATCH_W, 2: dispatch slots per cycle.
- ISSUE_W, 2: broadcast ports per cycle.
- MAX_LATENCY, 4: shift/delay vector width.
- LAT_ALU, 1; LAT_BR, 1; LAT_MUL, 3; LAT_LDST, 4: class latencies. Legal range is 1..MAX_LATENCY; an elaboration error is raised otherwise.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- disp_valid  in  DISPATCH_W  slot k is valid.
- disp_src  in  DISPATCH_W*2*PHY_REG_SEL  source tags; slot k src j is at index (2k+j).
- disp_wr  in  DISPATCH_W  slot k writes a destination.
- disp_dst  in  DISPATCH_W*PHY_REG_SEL  destination tags.
- disp_type  in  DISPATCH_W*2  class per slot: 0 ALU, 1 BRANCH, 2 MUL, 3 LDST.
- src_ready  out  DISPATCH_W*2  shift_r bit 0 of the looked-up entry.
- src_match  out  DISPATCH_W*2  match bit of the looked-up entry.
- src_shift  out  DISPATCH_W*2*MAX_LATENCY  shift_r of the looked-up entry.
- src_delay  out  DISPATCH_W*2*MAX_LATENCY  delay of the looked-up entry.
- bc_valid  in  ISSUE_W  tag broadcast (instruction issued).
- bc_dst  in  ISSUE_W*PHY_REG_SEL  broadcast tags.
- flush  in  1  recovery pulse.
- flush_mask  in  PHY_REG_NUM  registers whose producers are squashed.

## Operation
- Per-entry state: match (1 bit), shift_r (MAX_LATENCY bits), delay (MAX_LATENCY bits).
- Reset value of every entry: match=1, shift_r and delay all ones. All outputs are combinational; after reset, every src_ready and src_match reads 1 and every src_shift and src_delay reads all ones, for any tag. When a slot is invalid, its outputs are forced to 0.
- Delay encoding for latency L: the top (MAX_LATENCY+1-L) bits are set and the rest cleared. With MAX_LATENCY=4: L=1 gives 1111, L=3 gives 1100, L=4 gives 1000.
- Allocation (disp_valid & disp_wr): the entry gets match=0, shift_r=0 and delay set from disp_type. If several slots share a dst, the highest slot index wins.
- Broadcast: the entry gets match=1 and shift_r=delay, where delay is the value after any same-edge allocation.
- Countdown: any entry with match=1 and shift_r[0]=0 that is not otherwise written this edge is arithmetic-right-shifted by 1. A broadcast entry does not shift on its broadcast edge.
- Flush: every entry with its flush_mask bit set returns to the reset value. Flush-masked entries ignore allocation and broadcast on that edge; unmasked entries update normally.
- Write precedence per entry: reset > flush > allocation > broadcast > shift.
- Lookup forwarding, evaluated in this order (first hit wins):
  - (a) the nearest lower valid writing slot j<k with dst equal to the source supplies match=0, shift=0 and that slot's delay;
  - (b) else a same-cycle bc_valid with an equal tag supplies match=1, shift=delay[tag];
  - (c) else the stored entry is used.
- Lookups never see flush; dispatch is suppressed by the pipeline during flush.

## Timing
- Lookup is zero latency: outputs settle combinationally in the same cycle as disp_src.
- Allocation and broadcast are visible in stored state from the next cycle.
- For latency L with broadcast at edge T: src_ready reads 1 in the cycle after edge T+L-1. For L=1 that is the cycle immediately after the broadcast edge.
- Simultaneous allocation and broadcast to the same tag: allocation wins for match and shift_r. This case is illegal in practice; an assertion must flag it.
- Asserting reset mid-countdown clears all entries immediately, without waiting for a clock edge.

## Test plan
- Reset check: after reset, look up tags 0, 17 and 63 -> ready=1, match=1, shift=1111, delay=1111.
- MUL countdown: allocate p5 as MUL in cycle 0, broadcast p5 in cycle 3 -> shift reads 1100, then 1110, then 1111; ready rises exactly 2 cycles after the broadcast edge.
- Intra-group forwarding: slot0 writes p9 as LDST while slot1 src0=p9 in the same cycle -> slot1 sees match=0, shift=0000, delay=1000.
- Broadcast forwarding and WAW: broadcast p12 while dispatching src p12 -> match=1, shift=delay[p12]. Two slots both write p20 (slot0 ALU, slot1 MUL) -> the stored delay is 1100.
- Flush: allocate p3 and p4, set flush_mask bit 3 -> p3 reads ready with 1111, p4 still has match=0; a broadcast to p3 on the flush edge is ignored.
- Async reset: pulse reset between clock edges while p7 is mid-countdown -> p7 reads ready=1 and shift=1111 before the next edge.

Source files
------------

// File: rtl/wakeup_scoreboard.sv
// Per-physical-register wakeup scoreboard: tracks match/countdown/delay per tag and
// serves combinational lookups with intra-group and broadcast forwarding.
module wakeup_scoreboard #(
  parameter int PHY_REG_NUM = 64,
  parameter int PHY_REG_SEL = 6,
  parameter int DISPATCH_W  = 2,
  parameter int ISSUE_W     = 2,
  parameter int MAX_LATENCY = 4,
  parameter int LAT_ALU     = 1,
  parameter int LAT_BR      = 1,
  parameter int LAT_MUL     = 3,
  parameter int LAT_LDST    = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [DISPATCH_W-1:0]                 disp_valid,
  input  logic [DISPATCH_W*2*PHY_REG_SEL-1:0]   disp_src,
  input  logic [DISPATCH_W-1:0]                 disp_wr,
  input  logic [DISPATCH_W*PHY_REG_SEL-1:0]     disp_dst,
  input  logic [DISPATCH_W*2-1:0]               disp_type,
  output logic [DISPATCH_W*2-1:0]               src_ready,
  output logic [DISPATCH_W*2-1:0]               src_match,
  output logic [DISPATCH_W*2*MAX_LATENCY-1:0]   src_shift,
  output logic [DISPATCH_W*2*MAX_LATENCY-1:0]   src_delay,
  input  logic [ISSUE_W-1:0]                    bc_valid,
  input  logic [ISSUE_W*PHY_REG_SEL-1:0]        bc_dst,
  input  logic                                  flush,
  input  logic [PHY_REG_NUM-1:0]                flush_mask
);

  localparam int NSRC = DISPATCH_W * 2;

  if (LAT_ALU  < 1 || LAT_ALU  > MAX_LATENCY ||
      LAT_BR   < 1 || LAT_BR   > MAX_LATENCY ||
      LAT_MUL  < 1 || LAT_MUL  > MAX_LATENCY ||
      LAT_LDST < 1 || LAT_LDST > MAX_LATENCY) begin : g_bad_latency
    $error("wakeup_scoreboard: class latency outside 1..MAX_LATENCY");
  end

  if (PHY_REG_NUM != (1 << PHY_REG_SEL)) begin : g_bad_tag_width
    $error("wakeup_scoreboard: PHY_REG_SEL must equal log2(PHY_REG_NUM)");
  end

  // Latency L keeps the top (MAX_LATENCY+1-L) bits set.
  function automatic logic [MAX_LATENCY-1:0] lat_to_delay(input int lat);
    logic [MAX_LATENCY-1:0] d;
    for (int i = 0; i < MAX_LATENCY; i++) begin
      d[i] = (i >= lat - 1);
    end
    return d;
  endfunction

  function automatic int class_lat(input logic [1:0] ty);
    case (ty)
      2'd0:    return LAT_ALU;
      2'd1:    return LAT_BR;
      2'd2:    return LAT_MUL;
      default: return LAT_LDST;
    endcase
  endfunction

  function automatic logic [MAX_LATENCY-1:0] asr1(input logic [MAX_LATENCY-1:0] v);
    logic signed [MAX_LATENCY-1:0] sv;
    sv = $signed(v);
    return MAX_LATENCY'(sv >>> 1);
  endfunction

  logic                   match_r [PHY_REG_NUM];
  logic [MAX_LATENCY-1:0] shift_r [PHY_REG_NUM];
  logic [MAX_LATENCY-1:0] delay_r [PHY_REG_NUM];

  logic [DISPATCH_W-1:0]  slot_alloc;
  logic [MAX_LATENCY-1:0] slot_delay [DISPATCH_W];

  logic [PHY_REG_NUM-1:0] alloc_hit;
  logic [PHY_REG_NUM-1:0] bc_hit;
  logic [MAX_LATENCY-1:0] alloc_delay [PHY_REG_NUM];
  logic [PHY_REG_NUM-1:0] flush_hit;
  logic                   alloc_bc_conflict;

  always_comb begin
    for (int k = 0; k < DISPATCH_W; k++) begin
      slot_alloc[k] = disp_valid[k] & disp_wr[k];
      slot_delay[k] = lat_to_delay(class_lat(disp_type[2*k +: 2]));
    end
  end

  // Decode this edge's writes per entry; ascending slot order lets the highest slot win a shared dst.
  always_comb begin
    alloc_hit = '0;
    bc_hit    = '0;
    for (int e = 0; e < PHY_REG_NUM; e++) begin
      alloc_delay[e] = '0;
    end
    for (int k = 0; k < DISPATCH_W; k++) begin
      if (slot_alloc[k]) begin
        alloc_hit[disp_dst[k*PHY_REG_SEL +: PHY_REG_SEL]]   = 1'b1;
        alloc_delay[disp_dst[k*PHY_REG_SEL +: PHY_REG_SEL]] = slot_delay[k];
      end
    end
    for (int b = 0; b < ISSUE_W; b++) begin
      if (bc_valid[b]) begin
        bc_hit[bc_dst[b*PHY_REG_SEL +: PHY_REG_SEL]] = 1'b1;
      end
    end
    flush_hit         = flush ? flush_mask : '0;
    alloc_bc_conflict = |(alloc_hit & bc_hit & ~flush_hit);
  end

  // State update: flush > allocation > broadcast > countdown.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int e = 0; e < PHY_REG_NUM; e++) begin
        match_r[e] <= 1'b1;
        shift_r[e] <= '1;
        delay_r[e] <= '1;
      end
    end else begin
      for (int e = 0; e < PHY_REG_NUM; e++) begin
        if (flush_hit[e]) begin
          match_r[e] <= 1'b1;
          shift_r[e] <= '1;
          delay_r[e] <= '1;
        end else if (alloc_hit[e]) begin
          match_r[e] <= 1'b0;
          shift_r[e] <= '0;
          delay_r[e] <= alloc_delay[e];
        end else if (bc_hit[e]) begin
          match_r[e] <= 1'b1;
          shift_r[e] <= delay_r[e];
        end else if (match_r[e] && !shift_r[e][0]) begin
          shift_r[e] <= asr1(shift_r[e]);
        end
      end
    end
  end

  // Lookup: nearest lower writing slot beats a same-cycle broadcast, which beats stored state.
  always_comb begin
    logic [PHY_REG_SEL-1:0] tag;
    logic                   m;
    logic [MAX_LATENCY-1:0] s;
    logic [MAX_LATENCY-1:0] d;
    int                     k;
    src_ready = '0;
    src_match = '0;
    src_shift = '0;
    src_delay = '0;
    for (int i = 0; i < NSRC; i++) begin
      k   = i / 2;
      tag = disp_src[i*PHY_REG_SEL +: PHY_REG_SEL];
      m   = match_r[tag];
      s   = shift_r[tag];
      d   = delay_r[tag];
      for (int b = 0; b < ISSUE_W; b++) begin
        if (bc_valid[b] && bc_dst[b*PHY_REG_SEL +: PHY_REG_SEL] == tag) begin
          m = 1'b1;
          s = delay_r[tag];
        end
      end
      for (int jj = 0; jj < DISPATCH_W; jj++) begin
        if (jj < k && slot_alloc[jj] && disp_dst[jj*PHY_REG_SEL +: PHY_REG_SEL] == tag) begin
          m = 1'b0;
          s = '0;
          d = slot_delay[jj];
        end
      end
      if (disp_valid[k]) begin
        src_ready[i]                          = s[0];
        src_match[i]                          = m;
        src_shift[i*MAX_LATENCY +: MAX_LATENCY] = s;
        src_delay[i*MAX_LATENCY +: MAX_LATENCY] = d;
      end
    end
  end

  a_no_alloc_bc_same_tag: assert property (@(posedge clk) disable iff (reset) !alloc_bc_conflict)
    else $error("wakeup_scoreboard: allocation and broadcast to the same tag on one edge");

endmodule
